stage_fetch: RTL and testbench

STAGE_FETCH -- requirements
Module: stage_fetch

---
 rtl/mollusc_pkg.sv | 16 +
 rtl/fetch_skid.sv | 40 ++++
 rtl/stage_fetch.sv | 149 ++++++++++++++
 tb/tb_stage_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mollusc_pkg.sv
// mollusc_pkg: shared constants and types for the mollusc fetch stage.
//   NOP_INSTR   - word presented on instr whenever valid is low
//   INSTR_BYTES - fetch address increment
//   fetch_state_t - fetch sequencer state encoding
package mollusc_pkg;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry holding register for a fetched word that arrived
// while decode was stalled.
//   clk, rst      - clock, synchronous active-high reset
//   clr           - drop any held word (redirect)
//   load          - capture load_pc/load_instr, set full
//   unload        - word has been moved to the outputs, clear full
//   full          - a word is held
//   pc, instr     - the held word and its address
module fetch_skid
    import mollusc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [31:0] load_pc,
    input  logic [31:0] load_instr,
    input  logic        unload,
    output logic        full,
    output logic [31:0] pc,
    output logic [31:0] instr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            full  <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (clr) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            pc    <= load_pc;
            instr <= load_instr;
        end else if (unload) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/stage_fetch.sv
// stage_fetch: instruction fetch stage with a single outstanding memory
// request, a one-entry skid for words returning under stall, and redirect.
//   clk, rst                 - clock, synchronous active-high reset
//   stall                    - decode cannot accept; outputs hold
//   jump_valid, jump_target  - redirect (low two target bits ignored)
//   imem_req/addr/ready      - request handshake to instruction memory
//   imem_rvalid/rdata        - response from instruction memory
//   pc, instr, valid         - registered instruction to decode
//
// state | meaning
// REQ   | request driven at fetch_pc, waiting for imem_ready
// WAIT  | one request outstanding; discard marks its response as stale
// HOLD  | response parked in the skid until stall drops
module stage_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mollusc_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        valid
);
    import mollusc_pkg::*;

    fetch_state_t state;
    logic         discard;
    logic [31:0]  fetch_pc;

    logic         accept;
    logic         rsp_keep;
    logic         outstanding;
    logic [31:0]  rsp_pc;
    logic [31:0]  jump_addr;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_full;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;

    // Gated by rst so no request escapes during the reset cycle.
    assign imem_req  = (state == ST_REQ) && !rst;
    assign imem_addr = fetch_pc;
    assign accept    = imem_req && imem_ready;

    // fetch_pc already advanced past the outstanding request.
    assign rsp_pc    = fetch_pc - INSTR_BYTES;
    assign jump_addr = jump_target & ~32'h3;

    assign rsp_keep    = (state == ST_WAIT) && imem_rvalid && !discard && !jump_valid && !rst;
    assign skid_load   = rsp_keep && stall;
    assign skid_unload = (state == ST_HOLD) && skid_full && !stall && !jump_valid && !rst;

    // A request still in flight after this edge; its response must be dropped.
    assign outstanding = accept || ((state == ST_WAIT) && !imem_rvalid);

    fetch_skid u_skid (
        .clk        (clk),
        .rst        (rst),
        .clr        (jump_valid),
        .load       (skid_load),
        .load_pc    (rsp_pc),
        .load_instr (imem_rdata),
        .unload     (skid_unload),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pc       <= '0;
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
            // Memory may still answer a request issued before reset.
            if (outstanding) begin
                state   <= ST_WAIT;
                discard <= 1'b1;
            end else begin
                state   <= ST_REQ;
                discard <= 1'b0;
            end
        end else if (jump_valid) begin
            fetch_pc <= jump_addr;
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
            if (outstanding) begin
                state   <= ST_WAIT;
                discard <= 1'b1;
            end else begin
                state   <= ST_REQ;
                discard <= 1'b0;
            end
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + INSTR_BYTES;
            end

            if (!stall) begin
                if (rsp_keep) begin
                    pc    <= rsp_pc;
                    instr <= imem_rdata;
                    valid <= 1'b1;
                end else if (skid_unload) begin
                    pc    <= skid_pc;
                    instr <= skid_instr;
                    valid <= 1'b1;
                end else begin
                    instr <= NOP_INSTR;
                    valid <= 1'b0;
                end
            end

            case (state)
                ST_REQ: begin
                    if (accept) begin
                        state   <= ST_WAIT;
                        discard <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        state   <= (discard || !stall) ? ST_REQ : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state <= ST_REQ;
                    end
                end
                default: begin
                    state   <= ST_REQ;
                    discard <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_fetch.sv
// tb_stage_fetch: directed scenarios plus randomized traffic for stage_fetch,
// compared every cycle against a transaction-level reference model.
module tb_stage_fetch;
    import mollusc_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, stall, jump_valid, imem_ready, imem_rvalid, imem_req, valid;
    logic [31:0] jump_target, imem_rdata, imem_addr, pc, instr;

    int checks = 0;
    int errors = 0;

    // memory environment
    logic        rdy_always;
    int          lat_min, lat_max;
    logic        beef;
    logic [31:0] key;
    logic        mem_pend;
    int          mem_cnt;
    logic [31:0] mem_data;
    logic        dut_acc;
    logic [31:0] acc_addr;
    logic        last_req;

    // reference model
    logic [31:0] m_fpc, m_req_pc, m_pc, m_instr, m_skid_pc, m_skid_instr;
    logic        m_out, m_drop, m_valid, m_skid_full, m_req;

    stage_fetch #(.RESET_PC(RPC)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .instr       (instr),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        return (beef && addr == 32'h8) ? 32'hDEAD_BEEF : (addr ^ key);
    endfunction

    // One outstanding fetch at most; a fetched word lands in the outputs
    // if decode is free, else waits in a one-deep queue.
    task automatic model_edge();
        logic        acc, rsp, got;
        logic [31:0] wpc;
        acc = m_req && imem_ready;
        rsp = m_out && imem_rvalid;
        if (rst) begin
            m_fpc = RPC; m_pc = '0; m_instr = NOP_INSTR; m_valid = 1'b0; m_skid_full = 1'b0;
            m_out = m_out && !imem_rvalid;
            m_drop = m_out;
        end else if (jump_valid) begin
            m_fpc = jump_target & ~32'h3; m_instr = NOP_INSTR; m_valid = 1'b0; m_skid_full = 1'b0;
            m_out = (m_out && !imem_rvalid) || acc;
            m_drop = m_out;
        end else begin
            got = rsp && !m_drop;
            wpc = m_req_pc;
            if (rsp) begin m_out = 1'b0; m_drop = 1'b0; end
            if (acc) begin
                m_req_pc = m_fpc; m_fpc = m_fpc + 32'd4; m_out = 1'b1; m_drop = 1'b0;
            end
            if (!stall) begin
                if (got) begin
                    m_pc = wpc; m_instr = imem_rdata; m_valid = 1'b1;
                end else if (m_skid_full) begin
                    m_pc = m_skid_pc; m_instr = m_skid_instr; m_valid = 1'b1; m_skid_full = 1'b0;
                end else begin
                    m_instr = NOP_INSTR; m_valid = 1'b0;
                end
            end else if (got) begin
                m_skid_pc = wpc; m_skid_instr = imem_rdata; m_skid_full = 1'b1;
            end
        end
    endtask

    task automatic mem_edge();
        if (imem_rvalid) mem_pend = 1'b0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (dut_acc) begin
            mem_pend = 1'b1;
            mem_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
            mem_data = word_of(acc_addr);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic jv, input logic [31:0] jt);
        rst = r; stall = s; jump_valid = jv; jump_target = jt;
        imem_ready  = rdy_always ? 1'b1 : ($urandom_range(0, 3) != 0);
        imem_rvalid = mem_pend && (mem_cnt == 0);
        imem_rdata  = imem_rvalid ? mem_data : $urandom;
        m_req = !r && !m_out && !m_skid_full;
        #2;
        last_req = imem_req;
        chk("imem_req", 32'(imem_req), 32'(m_req));
        if (!r) chk("imem_addr", imem_addr, m_fpc);
        dut_acc  = imem_req && imem_ready;
        acc_addr = imem_addr;
        @(posedge clk);
        model_edge();
        mem_edge();
        #1;
        chk("valid", 32'(valid), 32'(m_valid));
        chk("pc", pc, m_pc);
        chk("instr", instr, m_instr);
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        found;
        logic        r, s, jv;
        logic [31:0] jt;

        rst = 1'b1; stall = 1'b0; jump_valid = 1'b0; jump_target = '0;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        rdy_always = 1'b1; lat_min = 1; lat_max = 1; beef = 1'b0; key = '0;
        mem_pend = 1'b0; mem_cnt = 0; mem_data = '0; dut_acc = 1'b0; acc_addr = '0; last_req = 1'b0;
        m_fpc = RPC; m_req_pc = '0; m_pc = '0; m_instr = NOP_INSTR; m_skid_pc = '0; m_skid_instr = '0;
        m_out = 1'b0; m_drop = 1'b0; m_valid = 1'b0; m_skid_full = 1'b0; m_req = 1'b0;
        @(posedge clk); #1;

        // streaming fetch, data = address
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, NOP_INSTR);
        chk("rst_valid", 32'(valid), 32'h0);
        exp_pc = 32'h0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0);
            chk("seq_valid", 32'(valid), 32'((i % 2) == 1));
            if (valid) begin
                chk("seq_pc", pc, exp_pc);
                chk("seq_instr", instr, exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
        end

        // word returning under stall goes to the skid
        beef = 1'b1;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("pre_stall_pc", pc, 32'h4);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        chk("stall_hold_pc", pc, 32'h4);
        chk("stall_hold_instr", instr, 32'h4);
        chk("stall_hold_valid", 32'(valid), 32'h1);
        chk("stall_no_req", 32'(imem_req), 32'h0);
        cyc(0, 0, 0, 0);
        chk("skid_pc", pc, 32'h8);
        chk("skid_instr", instr, 32'hDEAD_BEEF);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            cyc(0, 0, 0, 0);
            if (valid) begin
                found = 1'b1;
                chk("after_skid_pc", pc, 32'hC);
            end
        end
        chk("after_skid_found", 32'(found), 32'h1);
        beef = 1'b0;

        // redirect while waiting
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        lat_min = 2; lat_max = 2;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h100);
        chk("jmp_valid0", 32'(valid), 32'h0);
        lat_min = 1; lat_max = 1;
        cyc(0, 0, 0, 0);
        chk("jmp_stale_dropped", 32'(valid), 32'h0);
        chk("jmp_req", 32'(imem_req), 32'h1);
        chk("jmp_addr", imem_addr, 32'h100);
        cyc(0, 0, 0, 0);
        chk("jmp_valid1", 32'(valid), 32'h0);
        cyc(0, 0, 0, 0);
        chk("jmp_word_pc", pc, 32'h100);
        chk("jmp_word_valid", 32'(valid), 32'h1);

        // redirect coinciding with rvalid under stall, misaligned target
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 1, 32'h103);
        chk("jr_valid", 32'(valid), 32'h0);
        chk("jr_addr", imem_addr, 32'h100);
        chk("jr_req", 32'(imem_req), 32'h1);

        // address wrap at the top of memory
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (imem_req && imem_addr == 32'hFFFF_FFFC) begin
                found = 1'b1;
                cyc(0, 0, 0, 0);
                chk("wrap_addr", imem_addr, 32'h0);
            end else begin
                cyc(0, 0, 0, 0);
            end
        end
        chk("wrap_found", 32'(found), 32'h1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

        // reset while a response is outstanding
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        lat_min = 3; lat_max = 3; key = 32'h1234_0000;
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_cycle_req", 32'(last_req), 32'h0);
        lat_min = 1; lat_max = 1; key = '0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(0, 0, 0, 0);
            if (valid) begin
                found = 1'b1;
                chk("rst_first_pc", pc, RPC);
                chk("rst_first_instr", instr, RPC);
            end
        end
        chk("rst_first_found", 32'(found), 32'h1);

        // randomized traffic
        rdy_always = 1'b0; lat_min = 1; lat_max = 3; key = $urandom;
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 2) == 0);
            jv = ($urandom_range(0, 19) == 0);
            jt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc(r, s, jv, jt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
